// File: rtl/apexii_ddio_deser.sv
// DDIO input deserializer: packs RATIO beats of {ddio_l, ddio_h} into one word behind a small FIFO.
// Optional build macro APEXII_DDIO_DESER_HALFSLIP_EN selects half-beat (one DDR bit) slip.
module apexii_ddio_deser #(
    parameter int LANES      = 4,
    parameter int RATIO      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clkena,
    input  logic [LANES-1:0]             ddio_h,
    input  logic [LANES-1:0]             ddio_l,
    input  logic                         slip,
    input  logic                         ovf_clr,
    output logic [2*LANES*RATIO-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic [$clog2(RATIO)-1:0]     beat_cnt
);
    localparam int BW   = 2 * LANES;
    localparam int WW   = BW * RATIO;
    localparam int CW   = $clog2(RATIO);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_PACK = 2'd1,
        ST_SLIP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_beat_cnt;
    logic [WW-1:0]      r_word;
    logic [WW-1:0]      r_done_word;
    logic               r_push;
    logic               r_slip_pend;
    logic [WW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr;
    logic [AW-1:0]      r_rd;
    logic [CNTW-1:0]    r_count;
    logic               r_valid;
    logic               r_overflow;

    logic [BW-1:0]      w_beat;
    logic [WW-1:0]      w_word_next;
    logic               w_slip_eff;
    logic               w_drop;
    logic               w_take;
    logic               w_last;
    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;
    logic [CNTW-1:0]    w_count_next;

`ifdef APEXII_DDIO_DESER_HALFSLIP_EN
    logic [LANES-1:0]   r_held_l;
    logic               r_half;

    // Half phase pairs the previous later bit with the current earlier bit; only entering it costs a beat.
    always_comb begin
        w_slip_eff = slip | r_slip_pend;
        w_drop     = clkena & w_slip_eff & ~r_half;
        if (r_half) begin
            w_beat = {ddio_h, r_held_l};
        end else begin
            w_beat = {ddio_l, ddio_h};
        end
    end

    // Held later bit and slip phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_held_l <= {LANES{1'b0}};
            r_half   <= 1'b0;
        end else if (clkena) begin
            r_held_l <= ddio_l;
            if (w_slip_eff) begin
                r_half <= ~r_half;
            end
        end
    end
`else
    // Whole-beat slip: the beat coinciding with an effective slip is dropped.
    always_comb begin
        w_slip_eff = slip | r_slip_pend;
        w_drop     = clkena & w_slip_eff;
        w_beat     = {ddio_l, ddio_h};
    end
`endif

    // Insert the current beat into its slot of the word under construction.
    always_comb begin
        w_take      = clkena & ~w_drop;
        w_last      = w_take & (r_beat_cnt == CW'(RATIO - 1));
        w_word_next = r_word;
        w_word_next[BW*r_beat_cnt +: BW] = w_beat;
    end

    // Alignment FSM, beat packing and completed-word staging.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_HUNT;
            r_beat_cnt  <= {CW{1'b0}};
            r_word      <= {WW{1'b0}};
            r_done_word <= {WW{1'b0}};
            r_push      <= 1'b0;
            r_slip_pend <= 1'b0;
        end else begin
            r_push <= w_last;
            if (w_last) begin
                r_done_word <= w_word_next;
            end
            if (clkena) begin
                r_slip_pend <= 1'b0;
            end else if (slip) begin
                r_slip_pend <= 1'b1;
            end
            if (w_take) begin
                r_word     <= w_word_next;
                r_beat_cnt <= w_last ? {CW{1'b0}} : r_beat_cnt + CW'(1);
            end
            case (r_state)
                ST_HUNT, ST_PACK: begin
                    if (clkena) begin
                        r_state <= w_drop ? ST_SLIP : ST_PACK;
                    end
                end
                ST_SLIP: begin
                    r_state <= (clkena & w_drop) ? ST_SLIP : ST_PACK;
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    // FIFO control: a push into a full FIFO survives only if the head pops in the same cycle.
    always_comb begin
        w_pop        = r_valid & out_ready;
        w_full       = (r_count == CNTW'(FIFO_DEPTH));
        w_push_ok    = r_push & (~w_full | w_pop);
        w_count_next = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = r_count + CNTW'(1);
            2'b01:   w_count_next = r_count - CNTW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers, valid flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {WW{1'b0}};
            end
            r_wr       <= {AW{1'b0}};
            r_rd       <= {AW{1'b0}};
            r_count    <= {CNTW{1'b0}};
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= r_done_word;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != {CNTW{1'b0}});
            if (r_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data  = r_mem[r_rd];
    assign out_valid = r_valid;
    assign overflow  = r_overflow;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_apexii_ddio_deser.sv
// Randomized bench for apexii_ddio_deser (default build) against a queue-based reference model.
module tb_apexii_ddio_deser;
    localparam int LANES = 4;
    localparam int RATIO = 4;
    localparam int DEPTH = 4;
    localparam int BW    = 2 * LANES;
    localparam int WW    = BW * RATIO;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clkena = 1'b0;
    logic [LANES-1:0] ddio_h = '0;
    logic [LANES-1:0] ddio_l = '0;
    logic             slip = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [1:0]       beat_cnt;

    apexii_ddio_deser #(.LANES(LANES), .RATIO(RATIO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .clkena(clkena), .ddio_h(ddio_h), .ddio_l(ddio_l),
        .slip(slip), .ovf_clr(ovf_clr), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted beats of the current word, FIFO contents, pending push.
    logic [BW-1:0] m_beats[$];
    logic [WW-1:0] m_fifo[$];
    logic [WW-1:0] m_pword;
    bit            m_pend;
    bit            m_slip_pend;
    bit            m_ovf;
    bit            m_rst_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit            pop;
        bit            set_ovf;
        bit            new_pend;
        logic [WW-1:0] w;
        if (!reset_n) begin
            m_beats.delete(); m_fifo.delete();
            m_pend = 0; m_slip_pend = 0; m_ovf = 0; m_rst_seen = 1;
            return;
        end
        m_rst_seen = 0;
        pop = (m_fifo.size() != 0) && out_ready;
        set_ovf = 0;
        if (m_pend) begin
            if (m_fifo.size() < DEPTH || pop) m_fifo.push_back(m_pword);
            else set_ovf = 1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (set_ovf) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        new_pend = 0;
        if (clkena) begin
            if (!(slip || m_slip_pend)) begin
                m_beats.push_back({ddio_l, ddio_h});
                if (m_beats.size() == RATIO) begin
                    w = '0;
                    for (int k = 0; k < RATIO; k++) w[k*BW +: BW] = m_beats[k];
                    m_pword = w;
                    new_pend = 1;
                    m_beats.delete();
                end
            end
            m_slip_pend = 0;
        end else if (slip) begin
            m_slip_pend = 1;
        end
        m_pend = new_pend;
    endtask

    task automatic step(input bit en, input logic [LANES-1:0] h, input logic [LANES-1:0] l,
                        input bit sl, input bit rdy, input bit clr, input bit rst_n);
        clkena = en; ddio_h = h; ddio_l = l; slip = sl;
        out_ready = rdy; ovf_clr = clr; reset_n = rst_n;
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", 64'(out_valid), 64'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) chk("data", 64'(out_data), 64'(m_fifo[0]));
        else if (m_rst_seen) chk("data_rst", 64'(out_data), 64'd0);
        chk("ovf", 64'(overflow), 64'(m_ovf));
        chk("bcnt", 64'(beat_cnt), 64'(m_beats.size()));
    endtask

    initial begin
        m_pend = 0; m_slip_pend = 0; m_ovf = 0; m_rst_seen = 0;
        #2;
        step(0, 4'd0, 4'd0, 0, 1, 0, 0);
        step(0, 4'd0, 4'd0, 0, 1, 0, 0);

        // Basic packing with fixed expectation.
        for (int i = 0; i < 4; i++) step(1, 4'(i + 1), 4'(i + 5), 0, 1, 0, 1);
        step(0, 4'd0, 4'd0, 0, 1, 0, 1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_word", 64'(out_data), 64'h84736251);
        step(0, 4'd0, 4'd0, 0, 1, 0, 1);
        chk("t1_valid_1cyc", 64'(out_valid), 64'd0);

        // clkena toggling: same word, beat_cnt holds on idle cycles.
        for (int i = 0; i < 8; i++) step(i % 2 == 0, 4'(i / 2 + 1), 4'(i / 2 + 5), 0, 0, 0, 1);
        step(0, 4'd0, 4'd0, 0, 0, 0, 1);
        chk("t2_word", 64'(out_data), 64'h84736251);

        // Back-pressure: five more words into a FIFO already holding one.
        for (int i = 0; i < 20; i++) step(1, 4'($urandom), 4'($urandom), 0, 0, 0, 1);
        step(0, 4'd0, 4'd0, 0, 0, 0, 1);
        chk("t3_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 5; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 1);
        step(0, 4'd0, 4'd0, 0, 1, 1, 1);
        chk("t3_ovf_clr", 64'(overflow), 64'd0);

        // Slip on beat 2 of a word.
        for (int i = 0; i < 10; i++) step(1, 4'(i), 4'(15 - i), i == 1, 1, 0, 1);

        // Random traffic: bursts, back-pressure, slips, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) < ((i / 500) % 2 ? 3 : 8),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 199) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
